// File: rtl/ota_mux_scheduler.sv
// Round-robin scheduler that time-shares one OTA comparator across four input pairs.
// Each conversion settles the mux, majority-votes NSAMP synchronized decisions and pulses ack.
module ota_mux_scheduler #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned NSAMP  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ota_out,
  output logic [1:0] ota_sel,
  output logic       ota_en,
  output logic [3:0] ack,
  output logic [3:0] result,
  output logic       busy
);

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned SW   = $clog2(NSAMP);
  localparam int unsigned OW   = $clog2(NSAMP + 1);
  localparam int unsigned HALF = NSAMP / 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DECIDE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic          sync1;
  logic          ota_s;

  logic [CW-1:0] settle_cnt;
  logic [SW-1:0] samp_cnt;
  logic [OW-1:0] ones;
  logic [1:0]    last_grant;

  logic [1:0]    ota_sel_nxt;
  logic          ota_en_nxt;
  logic [3:0]    ack_nxt;
  logic [3:0]    result_nxt;
  logic          busy_nxt;
  logic [CW-1:0] settle_cnt_nxt;
  logic [SW-1:0] samp_cnt_nxt;
  logic [OW-1:0] ones_nxt;
  logic [1:0]    last_grant_nxt;

  logic          grant_valid;
  logic [1:0]    grant_ch;
  logic [1:0]    cand;
  logic          settle_done;
  logic          samp_done;
  logic [OW-1:0] ones_sum;

  // Two-flop synchronizer for the asynchronous comparator decision
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      ota_s <= 1'b0;
    end else begin
      sync1 <= ota_out;
      ota_s <= sync1;
    end
  end

  // Round-robin search starting just after the previously served channel
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = last_grant;
    cand        = last_grant;
    for (int i = 1; i <= int'(NCH); i++) begin
      cand = last_grant + 2'(i);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  assign settle_done = (settle_cnt == CW'(SETTLE - 1));
  assign samp_done   = (samp_cnt == SW'(NSAMP - 1));
  assign ones_sum    = ones + OW'(ota_s);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (grant_valid) state_next = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_next = ST_SAMPLE;
      ST_SAMPLE: if (samp_done)   state_next = ST_DECIDE;
      ST_DECIDE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ota_sel_nxt    = ota_sel;
    ota_en_nxt     = ota_en;
    ack_nxt        = '0;
    result_nxt     = result;
    busy_nxt       = (state_next != ST_IDLE);
    settle_cnt_nxt = settle_cnt;
    samp_cnt_nxt   = samp_cnt;
    ones_nxt       = ones;
    last_grant_nxt = last_grant;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          ota_sel_nxt    = grant_ch;
          ota_en_nxt     = 1'b1;
          settle_cnt_nxt = '0;
          samp_cnt_nxt   = '0;
          ones_nxt       = '0;
        end else begin
          ota_en_nxt = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (!settle_done) settle_cnt_nxt = settle_cnt + CW'(1);
      end
      ST_SAMPLE: begin
        ones_nxt = ones_sum;
        if (samp_done) begin
          // Strict majority: a tie resolves to 0
          result_nxt[ota_sel] = (ones_sum > OW'(HALF));
          ack_nxt             = 4'b0001 << ota_sel;
          ota_en_nxt          = 1'b0;
          last_grant_nxt      = ota_sel;
        end else begin
          samp_cnt_nxt = samp_cnt + SW'(1);
        end
      end
      ST_DECIDE: begin
        ota_en_nxt = 1'b0;
      end
      default: begin
        ota_en_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      ota_sel    <= 2'd0;
      ota_en     <= 1'b0;
      ack        <= '0;
      result     <= '0;
      busy       <= 1'b0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      ones       <= '0;
      last_grant <= 2'd3;
    end else begin
      ota_sel    <= ota_sel_nxt;
      ota_en     <= ota_en_nxt;
      ack        <= ack_nxt;
      result     <= result_nxt;
      busy       <= busy_nxt;
      settle_cnt <= settle_cnt_nxt;
      samp_cnt   <= samp_cnt_nxt;
      ones       <= ones_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_ota_mux_scheduler.sv
// Directed bench for ota_mux_scheduler with default parameters (SETTLE=4, NSAMP=8).
// Cycle 0 is the IDLE cycle in which a request is first presented.
module tb_ota_mux_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ota_out;
  logic [1:0] ota_sel;
  logic       ota_en;
  logic [3:0] ack;
  logic [3:0] result;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ota_mux_scheduler #(.SETTLE(4), .NSAMP(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ota_out (ota_out),
    .ota_sel (ota_sel),
    .ota_en  (ota_en),
    .ack     (ack),
    .result  (result),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = 4'b0000;
    ota_out = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one conversion from cycle 0 and returns in the DECIDE cycle (13).
  // pattern[k] is the decision seen by sample k; it is driven two cycles
  // early to cover the synchronizer.
  task automatic run_conv(input int ch, input logic [7:0] pattern);
    req     = 4'b0001 << ch;
    ota_out = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) begin
        req = 4'b0000;
        chk("conv_sel", 8'(ota_sel), 8'(ch));
        chk("conv_en", 8'(ota_en), 8'd1);
      end
      ota_out = (c >= 3 && c <= 10) ? pattern[c-3] : 1'b0;
      if (c == 12) chk("conv_ack_early", 8'(ack), 8'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_ack;

    // Reset state and single conversion of channel 0
    do_reset();
    chk("rst_en", 8'(ota_en), 8'd0);
    chk("rst_sel", 8'(ota_sel), 8'd0);
    chk("rst_ack", 8'(ack), 8'd0);
    chk("rst_result", 8'(result), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    req     = 4'b0001;
    ota_out = 1'b1;
    tick();
    chk("c1_sel", 8'(ota_sel), 8'd0);
    chk("c1_en", 8'(ota_en), 8'd1);
    chk("c1_busy", 8'(busy), 8'd1);
    req = 4'b0000;
    for (int c = 2; c <= 12; c++) begin
      tick();
      chk("single_ack_idle", 8'(ack), 8'd0);
      chk("single_en_held", 8'(ota_en), 8'd1);
    end
    tick();
    chk("c13_ack", 8'(ack), 8'h1);
    chk("c13_result", 8'(result), 8'h1);
    chk("c13_busy", 8'(busy), 8'd1);
    chk("c13_en", 8'(ota_en), 8'd0);
    tick();
    chk("c14_busy", 8'(busy), 8'd0);
    chk("c14_ack", 8'(ack), 8'd0);

    // Round-robin with all requests held: first grant is channel 0
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 69; k++) begin
      tick();
      exp_ack = 4'b0000;
      if (k >= 13 && (k - 13) % 14 == 0) exp_ack = 4'b0001 << (((k - 13) / 14) % 4);
      chk("rr_ack", 8'(ack), 8'(exp_ack));
    end
    req = 4'b0000;
    tick();
    chk("rr_idle", 8'(busy), 8'd0);

    // Majority (5 of 8) then tie (4 of 8) on channel 2
    run_conv(2, 8'b0001_1111);
    chk("maj_ack", 8'(ack), 8'h4);
    chk("maj_result", 8'(result), 8'h4);
    tick();
    run_conv(2, 8'b0000_1111);
    chk("tie_ack", 8'(ack), 8'h4);
    chk("tie_result", 8'(result), 8'h0);
    tick();

    // One-cycle request on channel 1 still completes; no further grant
    run_conv(1, 8'b1111_1111);
    chk("drop_ack", 8'(ack), 8'h2);
    chk("drop_result", 8'(result), 8'h2);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("drop_no_grant", 8'(busy), 8'd0);
      chk("drop_no_ack", 8'(ack), 8'd0);
    end

    // Channel 2 with all-zero decisions leaves result[1] intact
    run_conv(2, 8'b0000_0000);
    chk("keep_ack", 8'(ack), 8'h4);
    chk("keep_result", 8'(result), 8'h2);
    tick();

    // Reset during SAMPLE of a channel 3 conversion
    req     = 4'b1000;
    ota_out = 1'b1;
    tick();
    chk("abort_sel", 8'(ota_sel), 8'd3);
    req = 4'b0000;
    for (int c = 2; c <= 8; c++) tick();
    chk("abort_busy_pre", 8'(busy), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_en", 8'(ota_en), 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_ack", 8'(ack), 8'd0);
    chk("abort_result", 8'(result), 8'd0);
    chk("abort_sel_rst", 8'(ota_sel), 8'd0);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("abort_no_ack", 8'(ack), 8'd0);
      chk("abort_idle", 8'(busy), 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ota_mux_scheduler.md
OTA_MUX_SCHEDULER -- requirements
Module: ota_mux_scheduler

Interface
REQ-001 SHALL have parameter SETTLE, default 4: OTA settle cycles after a channel switch, legal range 1-15.
REQ-002 SHALL have parameter NSAMP, default 8: OTA output samples per conversion, power of two, legal range 2-16.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 4: per-channel conversion request, level-sensitive.
REQ-006 SHALL have port ota_out, input, 1: digital OTA decision output, asynchronous to clk.
REQ-007 SHALL have port ota_sel, output, 2: input-pair mux select for the shared OTA.
REQ-008 SHALL have port ota_en, output, 1: OTA enable.
REQ-009 SHALL have port ack, output, 4: one-hot, one-cycle conversion-complete pulse per channel.
REQ-010 SHALL have port result, output, 4: last decision per channel, where 1 means Vip > Vin.
REQ-011 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass ota_out through a 2-flop synchronizer; only the second-flop output (ota_s) is used.
REQ-013 SHALL implement FSM states IDLE, SETTLE, SAMPLE and DECIDE.
REQ-014 SHALL, in IDLE with req==0, remain in IDLE with ota_en=0.
REQ-015 SHALL, in IDLE with req!=0, grant one channel by round-robin, searching last_grant+1, +2, +3, +4 mod 4.
REQ-016 SHALL, on a grant, load ota_sel with the granted channel, set ota_en=1, clear the settle and sample counters, and enter SETTLE.
REQ-017 SHALL hold ota_sel stable and ota_en=1 for the whole of SETTLE and SAMPLE.
REQ-018 SHALL remain in SETTLE exactly SETTLE cycles without counting ota_s, then enter SAMPLE.
REQ-019 SHALL remain in SAMPLE exactly NSAMP cycles, adding ota_s to the ones counter each cycle.
REQ-020 SHALL size the ones counter to hold NSAMP without wrap.
REQ-021 SHALL, on the edge ending the last SAMPLE cycle, write result[ota_sel] = (ones > NSAMP/2), so a tie yields 0.
REQ-022 SHALL, on that same edge, set ack[ota_sel]=1, clear ota_en, update last_grant=ota_sel, and enter DECIDE.
REQ-023 SHALL leave result bits of non-granted channels unchanged on that edge.
REQ-024 SHALL make DECIDE last exactly one cycle, clear ack on exit, and return to IDLE.
REQ-025 SHALL not start a new grant in DECIDE; arbitration happens only in IDLE.
REQ-026 SHALL give a fixed latency of SETTLE+NSAMP+1 cycles from the IDLE grant cycle to the DECIDE cycle, which is cycle 13 for defaults.
REQ-027 SHALL ignore req changes once a channel is granted; a deasserted req still completes and still gets ack.
REQ-028 SHALL treat a req held high after its ack as a new request, arbitrated fairly against the other channels.
REQ-029 SHALL guarantee no channel waits more than 3 conversions while its req is held.
REQ-030 SHALL drive ack with at most one bit set at any time.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, force: state=IDLE, ota_en=0, ota_sel=0, ack=0, result=0, busy=0, counters=0, synchronizer flops=0, last_grant=3.
REQ-032 SHALL, on reset asserted mid-conversion, abort the conversion with no ack pulse and no result write.
REQ-033 SHALL make channel 0 the first grant after reset when all req bits are high.

Verification
REQ-034 SHALL be verified by single conversion: rst then req=0001 and ota_out=1 constantly -> ota_sel=0 and ota_en=1 from cycle 1, ack=0001 in cycle 13 only, result=0001, busy low at cycle 14.
REQ-035 SHALL be verified by majority/tie: req=0100 with ota_s high for exactly 5 of 8 samples -> result[2]=1; with exactly 4 of 8 -> result[2]=0.
REQ-036 SHALL be verified by round-robin: req=1111 held -> ack order 0001, 0010, 0100, 1000, 0001, with 14 cycles between successive acks.
REQ-037 SHALL be verified by request drop: req=0010 for 1 cycle then 0000 -> conversion completes, ack=0010 at cycle 13, no further grant.
REQ-038 SHALL be verified by reset mid-SAMPLE: rst high at cycle 8 of a channel 3 conversion -> next cycle has ota_en=0, busy=0, no ack pulse, result=0000.
REQ-039 SHALL be verified by result retention: converting channel 1 then channel 2 with differing ota_out values -> result[1] unchanged after channel 2 ack.
